enigma_step_ctrl: RTL and testbench
===================================

Name: enigma_step_ctrl

Overview:
- Sequencing controller for the Enigma rotor datapath.
- Owns the three rotor positions and applies odometer stepping, including the double-step anomaly, before each character.
- Launches the encode datapath with a start/done handshake, then returns the result on a valid/ready output channel.
- Sits between the pin-level command decoder and the rotor/reflector chain inside `top`.

Parameters:
- NOTCH_R, 21, turnover position of the right rotor (V, rotor III).
- NOTCH_M, 4, turnover position of the middle rotor (E, rotor II).
- NOTCH_L, 16, turnover position of the left rotor (Q, rotor I); informational only, since the left rotor never drives a further step.
- TIMEOUT, 15, maximum cycles to wait for enc_done; used only when ENIGMA_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; every flop is on posedge clk.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  controller accepts a command this cycle.
- cmd_op  in  2  00 = encrypt character, 01 = load rotor position, 10 = zero all positions, 11 = reserved.
- cmd_sel  in  2  rotor select for load: 0 = right, 1 = middle, 2 = left, 3 = ignored.
- cmd_data  in  5  character for encrypt, or position for load; legal range 0..25.
- pos_l, pos_m, pos_r  out  5 each  current rotor positions, driven to the datapath.
- enc_start  out  1  one-cycle pulse that launches the datapath.
- enc_in  out  5  character under encode; held stable from enc_start until enc_done.
- enc_done  in  1  datapath result is valid this cycle.
- enc_out  in  5  datapath result.
- out_valid  out  1  result is available.
- out_char  out  5  result character.
- out_ready  in  1  consumer accepts the result.
- err  out  1  one-cycle pulse on an illegal command or a timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous): pos_l = pos_m = pos_r = 0, state = IDLE, enc_start = 0, enc_in = 0, out_valid = 0, out_char = 0, err = 0, busy = 0, cmd_ready = 1.
- cmd_ready is 1 only in IDLE. A command is accepted on any cycle with cmd_valid & cmd_ready.
- States: IDLE, STEP, LAUNCH, WAIT, OUTPUT.
- IDLE, op 01: pos[cmd_sel] <= cmd_data; stay in IDLE. If cmd_data > 25 or cmd_sel = 3, positions are unchanged and err pulses.
- IDLE, op 10: all positions <= 0; stay in IDLE.
- IDLE, op 11: err pulses; no other effect.
- IDLE, op 00: if cmd_data > 25, err pulses and the state stays IDLE. Otherwise latch cmd_data into enc_in and go to STEP.
- STEP (one cycle): stepping decisions use pre-step values only.
  - m_at = (pos_m == NOTCH_M); r_at = (pos_r == NOTCH_R).
  - pos_r always increments.
  - pos_m increments if r_at | m_at.
  - pos_l increments if m_at.
  - Every increment wraps 25 -> 0.
  - Next state: LAUNCH.
- LAUNCH (one cycle): enc_start = 1, with the new positions already visible on pos_*. Next state: WAIT.
- WAIT: on enc_done, out_char <= enc_out, out_valid <= 1, go to OUTPUT. An enc_done seen in any other state is ignored.
- OUTPUT: out_valid and out_char are held until out_ready; on that cycle out_valid <= 0 and the state goes to IDLE.
- Latency: command accept -> enc_start is 2 cycles. enc_done -> out_valid is 1 cycle. With a zero-wait consumer, the minimum command-to-command spacing is 5 cycles plus datapath latency.
- Positions never change outside STEP, load, or zero.
- Reset asserted mid-operation: all state is abandoned immediately and any pending output is dropped. No err is generated.

Optional Feature:
- Macro: ENIGMA_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments every WAIT cycle. If it reaches TIMEOUT without enc_done:
  - err pulses;
  - the state goes to IDLE with out_valid = 0;
  - rotor positions keep their stepped values and are not rolled back.
- Not defined: no counter is synthesised, and WAIT holds indefinitely until enc_done.

Test Plan:
- Reset, then load r = 20, m = 3, l = 0 (ADU). Encrypt 3 characters with a 2-cycle datapath model -> positions after each character are (0,3,21), (0,4,22), (1,5,23). This covers the double step.
- pos_r = 25, pos_m = 25, pos_l = 25 with default notches, encrypt -> (25,25,0): only the right rotor steps and wraps.
- Encrypt with out_ready held low for 10 cycles -> out_valid and out_char stay stable, cmd_ready = 0 throughout, and a cmd_valid presented meanwhile is not accepted.
- Illegal commands: load with cmd_data = 26, encrypt with cmd_data = 30, op 11 -> err pulses once for each, positions are unchanged, state stays IDLE.
- rst_n pulsed low during WAIT, asynchronously mid-cycle -> all outputs return to reset values immediately, and a later enc_done is ignored.
- With ENIGMA_TIMEOUT_EN defined, enc_done is never asserted -> err pulses exactly TIMEOUT = 15 cycles after WAIT entry, the state returns to IDLE, and the positions show the stepped values.

Source files
------------

// File: rtl/enigma_step_ctrl.sv
// -----------------------------------------------------------------------------
// enigma_step_ctrl
//   Sequencing controller for the Enigma rotor datapath. Owns the three rotor
//   positions, applies odometer stepping (including the middle-rotor double
//   step) before each character, launches the encode datapath with a
//   start/done handshake and returns the result on a valid/ready channel.
//
// Optional feature macro: ENIGMA_TIMEOUT_EN
//   Defined     : WAIT gives up after TIMEOUT cycles without enc_done, pulses
//                 o_err and returns to IDLE (stepped positions are kept).
//   Not defined : no timeout counter; WAIT holds until enc_done.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_cmd_valid       command presented
//   o_cmd_ready       command accepted this cycle (high only in IDLE)
//   i_cmd_op[1:0]     00 encrypt, 01 load position, 10 zero all, 11 reserved
//   i_cmd_sel[1:0]    load target: 0 right, 1 middle, 2 left, 3 illegal
//   i_cmd_data[4:0]   character (encrypt) or position (load), 0..25
//   o_pos_l/m/r[4:0]  current rotor positions to the datapath
//   o_enc_start       one-cycle datapath launch pulse
//   o_enc_in[4:0]     character under encode, stable start..done
//   i_enc_done        datapath result valid
//   i_enc_out[4:0]    datapath result
//   o_out_valid       result available
//   o_out_char[4:0]   result character
//   i_out_ready       consumer accepts the result
//   o_err             one-cycle pulse on illegal command or timeout
//   o_busy            high in any state other than IDLE
// -----------------------------------------------------------------------------
module enigma_step_ctrl #(
  parameter logic [4:0]  NOTCH_R = 5'd21,
  parameter logic [4:0]  NOTCH_M = 5'd4,
  parameter logic [4:0]  NOTCH_L = 5'd16,
  parameter int unsigned TIMEOUT = 32'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [1:0] i_cmd_sel,
  input  logic [4:0] i_cmd_data,
  output logic [4:0] o_pos_l,
  output logic [4:0] o_pos_m,
  output logic [4:0] o_pos_r,
  output logic       o_enc_start,
  output logic [4:0] o_enc_in,
  input  logic       i_enc_done,
  input  logic [4:0] i_enc_out,
  output logic       o_out_valid,
  output logic [4:0] o_out_char,
  input  logic       i_out_ready,
  output logic       o_err,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STEP   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  // Advance one rotor position with the 25 -> 0 wrap.
  function automatic logic [4:0] inc_pos(input logic [4:0] p);
    logic [4:0] res;
    if (p >= 5'd25) begin
      res = 5'd0;
    end else begin
      res = p + 5'd1;
    end
    return res;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_pos_l, r_pos_m, r_pos_r;
  logic [4:0] w_pos_l_nxt, w_pos_m_nxt, w_pos_r_nxt;
  logic [4:0] r_enc_in, w_enc_in_nxt;
  logic [4:0] r_out_char, w_out_char_nxt;
  logic       r_out_valid, w_out_valid_nxt;
  logic       r_err, w_err_nxt;
  logic       r_enc_start, r_busy, r_cmd_ready;
  logic       w_accept;
  logic       w_m_at, w_r_at;

  // The left rotor has no successor, so its turnover never drives a step.
  logic       w_unused_l_turnover;
  assign w_unused_l_turnover = (r_pos_l == NOTCH_L);

`ifdef ENIGMA_TIMEOUT_EN
  localparam int unsigned TCNT_W = (TIMEOUT < 32'd2) ? 32'd1 : $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 32'd1);
  logic [TCNT_W-1:0] r_tcnt, w_tcnt_nxt;
`else
  logic       w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 32'd0);
`endif

  assign w_accept = i_cmd_valid & r_cmd_ready;
  // Stepping decisions look only at the pre-step positions.
  assign w_m_at   = (r_pos_m == NOTCH_M);
  assign w_r_at   = (r_pos_r == NOTCH_R);

  // Next-state, position and result logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_pos_l_nxt     = r_pos_l;
    w_pos_m_nxt     = r_pos_m;
    w_pos_r_nxt     = r_pos_r;
    w_enc_in_nxt    = r_enc_in;
    w_out_char_nxt  = r_out_char;
    w_out_valid_nxt = r_out_valid;
    w_err_nxt       = 1'b0;
`ifdef ENIGMA_TIMEOUT_EN
    w_tcnt_nxt      = r_tcnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (i_cmd_op)
            2'b00: begin
              if (i_cmd_data > 5'd25) begin
                w_err_nxt = 1'b1;
              end else begin
                w_enc_in_nxt = i_cmd_data;
                w_state_nxt  = S_STEP;
              end
            end
            2'b01: begin
              if ((i_cmd_data > 5'd25) || (i_cmd_sel == 2'd3)) begin
                w_err_nxt = 1'b1;
              end else begin
                case (i_cmd_sel)
                  2'd0:    w_pos_r_nxt = i_cmd_data;
                  2'd1:    w_pos_m_nxt = i_cmd_data;
                  2'd2:    w_pos_l_nxt = i_cmd_data;
                  default: w_err_nxt   = 1'b1;
                endcase
              end
            end
            2'b10: begin
              w_pos_l_nxt = 5'd0;
              w_pos_m_nxt = 5'd0;
              w_pos_r_nxt = 5'd0;
            end
            default: w_err_nxt = 1'b1;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_STEP: begin
        // A middle rotor sitting on its notch steps itself and the left
        // rotor: this is the double-step anomaly.
        w_pos_r_nxt = inc_pos(r_pos_r);
        if (w_r_at || w_m_at) begin
          w_pos_m_nxt = inc_pos(r_pos_m);
        end else begin
          w_pos_m_nxt = r_pos_m;
        end
        if (w_m_at) begin
          w_pos_l_nxt = inc_pos(r_pos_l);
        end else begin
          w_pos_l_nxt = r_pos_l;
        end
        w_state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
`ifdef ENIGMA_TIMEOUT_EN
        w_tcnt_nxt  = '0;
`endif
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_enc_done) begin
          w_out_char_nxt  = i_enc_out;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_OUTPUT;
        end
`ifdef ENIGMA_TIMEOUT_EN
        else if (r_tcnt == TCNT_LAST) begin
          w_err_nxt       = 1'b1;
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + {{(TCNT_W-1){1'b0}}, 1'b1};
        end
`else
        else begin
          w_state_nxt = S_WAIT;
        end
`endif
      end
      S_OUTPUT: begin
        if (i_out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_out_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  // State, positions and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pos_l     <= 5'd0;
      r_pos_m     <= 5'd0;
      r_pos_r     <= 5'd0;
      r_enc_in    <= 5'd0;
      r_out_char  <= 5'd0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_enc_start <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_pos_l     <= w_pos_l_nxt;
      r_pos_m     <= w_pos_m_nxt;
      r_pos_r     <= w_pos_r_nxt;
      r_enc_in    <= w_enc_in_nxt;
      r_out_char  <= w_out_char_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_err       <= w_err_nxt;
      // Flags are decoded from the next state so they line up with r_state.
      r_enc_start <= (w_state_nxt == S_LAUNCH);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_cmd_ready <= (w_state_nxt == S_IDLE);
    end
  end

`ifdef ENIGMA_TIMEOUT_EN
  // WAIT-cycle counter for the datapath timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= w_tcnt_nxt;
    end
  end
`endif

  assign o_cmd_ready = r_cmd_ready;
  assign o_pos_l     = r_pos_l;
  assign o_pos_m     = r_pos_m;
  assign o_pos_r     = r_pos_r;
  assign o_enc_start = r_enc_start;
  assign o_enc_in    = r_enc_in;
  assign o_out_valid = r_out_valid;
  assign o_out_char  = r_out_char;
  assign o_err       = r_err;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_enigma_step_ctrl
//   Directed bench for enigma_step_ctrl. A small datapath model answers each
//   enc_start with enc_out = (c + 3l + 5m + 7r) mod 26; expected characters
//   and positions are hand-computed constants. Results are checked by a
//   scoreboard monitor on the out_valid/out_ready handshake.
// -----------------------------------------------------------------------------
module tb_enigma_step_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic [1:0] i_cmd_op = 2'd0;
  logic [1:0] i_cmd_sel = 2'd0;
  logic [4:0] i_cmd_data = 5'd0;
  logic [4:0] o_pos_l, o_pos_m, o_pos_r;
  logic       o_enc_start;
  logic [4:0] o_enc_in;
  logic       i_enc_done;
  logic [4:0] i_enc_out;
  logic       o_out_valid;
  logic [4:0] o_out_char;
  logic       i_out_ready = 1'b1;
  logic       o_err;
  logic       o_busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];
  logic       dp_en = 1'b1;
  int         dp_lat = 1;

  enigma_step_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_op    (i_cmd_op),
    .i_cmd_sel   (i_cmd_sel),
    .i_cmd_data  (i_cmd_data),
    .o_pos_l     (o_pos_l),
    .o_pos_m     (o_pos_m),
    .o_pos_r     (o_pos_r),
    .o_enc_start (o_enc_start),
    .o_enc_in    (o_enc_in),
    .i_enc_done  (i_enc_done),
    .i_enc_out   (i_enc_out),
    .o_out_valid (o_out_valid),
    .o_out_char  (o_out_char),
    .i_out_ready (i_out_ready),
    .o_err       (o_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_pos(input string name, input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
    n_checks++;
    if ({o_pos_l, o_pos_m, o_pos_r} !== {l, m, r}) begin
      n_errors++;
      $display("FAIL %s: actual l/m/r=%0d/%0d/%0d required=%0d/%0d/%0d",
               name, o_pos_l, o_pos_m, o_pos_r, l, m, r);
    end
  endtask

  function automatic logic [4:0] dp_fn(input logic [4:0] c, input logic [4:0] l,
                                       input logic [4:0] m, input logic [4:0] r);
    int s;
    s = int'(c) + 3 * int'(l) + 5 * int'(m) + 7 * int'(r);
    return 5'(s % 26);
  endfunction

  // Datapath model: answers enc_start after dp_lat further cycles.
  initial begin
    logic [4:0] res;
    i_enc_done = 1'b0;
    i_enc_out  = 5'd0;
    forever begin
      @(posedge clk); #1;
      if (o_enc_start && dp_en) begin
        res = dp_fn(o_enc_in, o_pos_l, o_pos_m, o_pos_r);
        repeat (dp_lat) @(posedge clk);
        #1;
        i_enc_done = 1'b1;
        i_enc_out  = res;
        @(posedge clk); #1;
        i_enc_done = 1'b0;
        i_enc_out  = 5'd0;
      end
    end
  end

  // Scoreboard monitor: pops one expected character per output handshake.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n && o_out_valid && i_out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard: unexpected out_char=%0d, required no output", o_out_char);
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard out_char", 32'(o_out_char), 32'(e));
      end
    end
  end

  task automatic cmd(input logic [1:0] op, input logic [1:0] sel, input logic [4:0] data);
    int k;
    @(posedge clk); #1;
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_sel   = sel;
    i_cmd_data  = data;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (o_cmd_ready !== 1'b1 && k < 50);
    chk("cmd accepted", 32'(o_cmd_ready), 32'd1);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (o_busy !== 1'b0 && k < 100);
    chk(name, 32'(o_busy), 32'd0);
  endtask

  task automatic encrypt(input logic [4:0] c, input logic [4:0] exp_c,
                         input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
    cmd(2'b00, 2'd0, c);
    exp_q.push_back(exp_c);
    wait_idle("encrypt completes");
    chk_pos("positions after encrypt", l, m, r);
  endtask

  task automatic illegal(input string name, input logic [1:0] op, input logic [1:0] sel,
                         input logic [4:0] data, input logic [4:0] l, input logic [4:0] m,
                         input logic [4:0] r);
    cmd(op, sel, data);
    chk({name, " err pulse"}, 32'(o_err), 32'd1);
    chk({name, " busy"}, 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    chk({name, " err single"}, 32'(o_err), 32'd0);
    chk_pos({name, " positions"}, l, m, r);
  endtask

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    // Reset state.
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_pos("reset positions", 5'd0, 5'd0, 5'd0);
    chk("reset cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset out_valid", 32'(o_out_valid), 32'd0);
    chk("reset enc_start", 32'(o_enc_start), 32'd0);
    chk("reset err", 32'(o_err), 32'd0);
    rst_n = 1'b1;

    // Load ADU, then three characters covering the double step.
    cmd(2'b01, 2'd0, 5'd20);
    cmd(2'b01, 2'd1, 5'd3);
    cmd(2'b01, 2'd2, 5'd0);
    chk_pos("load ADU", 5'd0, 5'd3, 5'd20);
    encrypt(5'd7,  5'd13, 5'd0, 5'd3, 5'd21);
    encrypt(5'd0,  5'd18, 5'd0, 5'd4, 5'd22);
    encrypt(5'd25, 5'd6,  5'd1, 5'd5, 5'd23);

    // Only the right rotor steps and wraps.
    cmd(2'b01, 2'd0, 5'd25);
    cmd(2'b01, 2'd1, 5'd25);
    cmd(2'b01, 2'd2, 5'd25);
    encrypt(5'd1, 5'd19, 5'd25, 5'd25, 5'd0);

    // Back-pressure: result held, no command accepted meanwhile.
    i_out_ready = 1'b0;
    cmd(2'b00, 2'd0, 5'd10);
    exp_q.push_back(5'd9);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (o_out_valid !== 1'b1 && k < 30);
    chk("hold out_valid rises", 32'(o_out_valid), 32'd1);
    @(posedge clk); #1;
    i_cmd_valid = 1'b1;
    i_cmd_op    = 2'b10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold out_valid", 32'(o_out_valid), 32'd1);
      chk("hold out_char", 32'(o_out_char), 32'd9);
      chk("hold cmd_ready", 32'(o_cmd_ready), 32'd0);
    end
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    i_out_ready = 1'b1;
    wait_idle("hold release");
    chk_pos("zero command not accepted while busy", 5'd25, 5'd25, 5'd1);

    // Illegal commands leave everything unchanged.
    illegal("load 26",    2'b01, 2'd0, 5'd26, 5'd25, 5'd25, 5'd1);
    illegal("encrypt 30", 2'b00, 2'd0, 5'd30, 5'd25, 5'd25, 5'd1);
    illegal("op 11",      2'b11, 2'd0, 5'd5,  5'd25, 5'd25, 5'd1);
    illegal("sel 3",      2'b01, 2'd3, 5'd5,  5'd25, 5'd25, 5'd1);
    cmd(2'b10, 2'd0, 5'd0);
    chk_pos("zero all", 5'd0, 5'd0, 5'd0);

    // Asynchronous reset in WAIT; the late enc_done must be ignored.
    dp_lat = 4;
    cmd(2'b00, 2'd0, 5'd2);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (o_enc_start !== 1'b1 && k < 20);
    chk("reset test enc_start", 32'(o_enc_start), 32'd1);
    chk_pos("reset test stepped", 5'd0, 5'd0, 5'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_pos("async reset positions", 5'd0, 5'd0, 5'd0);
    chk("async reset busy", 32'(o_busy), 32'd0);
    chk("async reset cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("async reset enc_in", 32'(o_enc_in), 32'd0);
    chk("async reset err", 32'(o_err), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("late enc_done ignored out_valid", 32'(o_out_valid), 32'd0);
      chk("late enc_done ignored busy", 32'(o_busy), 32'd0);
    end
    dp_lat = 1;

`ifdef ENIGMA_TIMEOUT_EN
    // Datapath never answers: err after TIMEOUT WAIT cycles.
    dp_en = 1'b0;
    cmd(2'b00, 2'd0, 5'd3);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (o_enc_start !== 1'b1 && k < 20);
    @(posedge clk);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (o_err !== 1'b1 && k < 40);
    chk("timeout cycles", 32'(k), 32'd15);
    chk("timeout busy", 32'(o_busy), 32'd0);
    chk("timeout out_valid", 32'(o_out_valid), 32'd0);
    chk_pos("timeout positions kept", 5'd0, 5'd0, 5'd1);
    dp_en = 1'b1;
`endif

    repeat (5) @(posedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
